// File: rtl/instr_fetch_ctrl.sv
// PC sequencer for a 1-cycle synchronous-read instruction memory.
// Ports: clk/rst (sync, active-low); stall/jmp/call/ret/tgt from decode;
// mem_addr/mem_data to/from memory; instr/instr_vld/instr_pc to decode;
// err_ovf/err_unf sticky return-stack error flags.
module instr_fetch_ctrl #(
  parameter int NADDRE = 8,
  parameter int NBDATA = 12,
  parameter int SDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      jmp,
  input  logic                      call,
  input  logic                      ret,
  input  logic [$clog2(NADDRE)-1:0] tgt,
  output logic [$clog2(NADDRE)-1:0] mem_addr,
  input  logic [NBDATA-1:0]         mem_data,
  output logic [NBDATA-1:0]         instr,
  output logic                      instr_vld,
  output logic [$clog2(NADDRE)-1:0] instr_pc,
  output logic                      err_ovf,
  output logic                      err_unf
);

  localparam int AW = $clog2(NADDRE);
  localparam int SW = $clog2(SDEPTH + 1);
  localparam int IW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(NADDRE - 1);
  localparam logic [SW-1:0] FULL = SW'(SDEPTH);

  logic [AW-1:0] pc;
  logic [AW-1:0] dpc;
  logic          vld;
  logic [SW-1:0] sp;
  logic [AW-1:0] stack [SDEPTH];

  logic          do_jmp;
  logic          do_call;
  logic          do_ret;
  logic [IW-1:0] wi;
  logic [IW-1:0] ri;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] x);
    return (x == LAST) ? '0 : x + 1'b1;
  endfunction

  // Controls belong to the instruction on instr, so a
  // bubble carries no control; jmp > call > ret.
  assign do_jmp  = vld & jmp;
  assign do_call = vld & call & ~jmp;
  assign do_ret  = vld & ret & ~jmp & ~call;

  assign wi = IW'(sp);
  assign ri = IW'(sp - 1'b1);

  // Re-reading dpc while stalled keeps mem_data stable.
  assign mem_addr  = stall ? dpc : pc;
  assign instr     = vld ? mem_data : '0;
  assign instr_vld = vld;
  assign instr_pc  = dpc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc      <= '0;
      dpc     <= '0;
      vld     <= 1'b0;
      sp      <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else if (!stall) begin
      dpc <= pc;
      vld <= 1'b0;
      unique case (1'b1)
        do_jmp: begin
          pc <= tgt;
        end
        do_call: begin
          pc <= tgt;
          if (sp != FULL) begin
            stack[wi] <= inc(dpc);
            sp        <= sp + 1'b1;
          end else begin
            err_ovf <= 1'b1;
          end
        end
        do_ret: begin
          if (sp != '0) begin
            pc <= stack[ri];
            sp <= sp - 1'b1;
          end else begin
            pc      <= '0;
            err_unf <= 1'b1;
          end
        end
        default: begin
          pc  <= inc(pc);
          vld <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: NADDRE=6, SDEPTH=2, memory word i = i+1.
// Expected (valid, pc) per cycle is queued on drive and popped on check.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jmp;
  logic        call;
  logic        ret;
  logic [2:0]  tgt;
  logic [2:0]  mem_addr;
  logic [11:0] mem_data;
  logic [11:0] instr;
  logic        instr_vld;
  logic [2:0]  instr_pc;
  logic        err_ovf;
  logic        err_unf;

  int runs  = 0;
  int fails = 0;

  typedef struct packed {
    logic       v;
    logic [2:0] pc;
  } exp_t;

  typedef struct packed {
    logic       j;
    logic       c;
    logic       r;
    logic [2:0] t;
    logic       v;
    logic [2:0] pc;
  } st_t;

  exp_t sb [$];

  always #5 clk = ~clk;

  // Synchronous-read memory with registered output.
  always_ff @(posedge clk) mem_data <= 12'(mem_addr + 3'd1);

  instr_fetch_ctrl #(
    .NADDRE(6),
    .NBDATA(12),
    .SDEPTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .jmp      (jmp),
    .call     (call),
    .ret      (ret),
    .tgt      (tgt),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .instr    (instr),
    .instr_vld(instr_vld),
    .instr_pc (instr_pc),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf)
  );

  function automatic st_t st(bit j, bit c, bit r, int t, bit v, int pc);
    return '{j, c, r, 3'(t), v, 3'(pc)};
  endfunction

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; jmp = 1'b0;
    call = 1'b0; ret = 1'b0; tgt = '0;
    repeat (2) @(posedge clk);
    #1;
    runs++;
    if (instr_vld !== 1'b0 || instr !== 12'd0 || mem_addr !== 3'd0) begin
      fails++;
      $display("FAIL reset: vld=%b instr=%0d addr=%0d, want 0 0 0",
               instr_vld, instr, mem_addr);
    end
    runs++;
    if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: ovf=%b unf=%b, want 0 0", err_ovf, err_unf);
    end
    rst = 1'b1;
    #1;
    runs++;
    if (mem_addr !== 3'd0 || instr_vld !== 1'b0) begin
      fails++;
      $display("FAIL release: addr=%0d vld=%b, want 0 0", mem_addr, instr_vld);
    end
  endtask

  task automatic test_sequential();
    st_t  s [8];
    exp_t e;
    for (int i = 0; i < 8; i++) s[i] = st(0, 0, 0, 0, 1, i % 6);
    foreach (s[i]) begin
      jmp = s[i].j; call = s[i].c; ret = s[i].r; tgt = s[i].t;
      sb.push_back('{s[i].v, s[i].pc});
      @(posedge clk); #1;
      e = sb.pop_front();
      runs++;
      if (instr_vld !== e.v || instr !== (e.v ? 12'(e.pc + 1) : 12'd0) ||
          (e.v && instr_pc !== e.pc)) begin
        fails++;
        $display("FAIL seq[%0d]: vld=%b pc=%0d instr=%0d, want vld=%b pc=%0d",
                 i, instr_vld, instr_pc, instr, e.v, e.pc);
      end
    end
  endtask

  task automatic test_jump();
    st_t  s [3];
    exp_t e;
    s = '{st(1, 0, 0, 4, 0, 0), st(0, 0, 0, 0, 1, 4), st(0, 0, 0, 0, 1, 5)};
    foreach (s[i]) begin
      jmp = s[i].j; call = s[i].c; ret = s[i].r; tgt = s[i].t;
      sb.push_back('{s[i].v, s[i].pc});
      @(posedge clk); #1;
      e = sb.pop_front();
      runs++;
      if (instr_vld !== e.v || instr !== (e.v ? 12'(e.pc + 1) : 12'd0) ||
          (e.v && instr_pc !== e.pc)) begin
        fails++;
        $display("FAIL jump[%0d]: vld=%b pc=%0d instr=%0d, want vld=%b pc=%0d",
                 i, instr_vld, instr_pc, instr, e.v, e.pc);
      end
    end
  endtask

  task automatic test_call_ret();
    st_t  s [10];
    exp_t e;
    s = '{st(1, 0, 0, 0, 0, 0), st(0, 0, 0, 0, 1, 0),
          st(0, 1, 0, 3, 0, 0), st(0, 0, 0, 0, 1, 3),
          st(0, 1, 0, 5, 0, 0), st(0, 0, 0, 0, 1, 5),
          st(0, 0, 1, 0, 0, 0), st(0, 0, 0, 0, 1, 4),
          st(0, 0, 1, 0, 0, 0), st(0, 0, 0, 0, 1, 1)};
    foreach (s[i]) begin
      jmp = s[i].j; call = s[i].c; ret = s[i].r; tgt = s[i].t;
      sb.push_back('{s[i].v, s[i].pc});
      @(posedge clk); #1;
      e = sb.pop_front();
      runs++;
      if (instr_vld !== e.v || instr !== (e.v ? 12'(e.pc + 1) : 12'd0) ||
          (e.v && instr_pc !== e.pc)) begin
        fails++;
        $display("FAIL call[%0d]: vld=%b pc=%0d instr=%0d, want vld=%b pc=%0d",
                 i, instr_vld, instr_pc, instr, e.v, e.pc);
      end
    end
    runs++;
    if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin
      fails++;
      $display("FAIL call_flags: ovf=%b unf=%b, want 0 0", err_ovf, err_unf);
    end
  endtask

  task automatic test_overflow();
    st_t  s [12];
    exp_t e;
    s = '{st(0, 1, 0, 2, 0, 0), st(0, 0, 0, 0, 1, 2),
          st(0, 1, 0, 3, 0, 0), st(0, 0, 0, 0, 1, 3),
          st(0, 1, 0, 4, 0, 0), st(0, 0, 0, 0, 1, 4),
          st(0, 0, 1, 0, 0, 0), st(0, 0, 0, 0, 1, 3),
          st(0, 0, 1, 0, 0, 0), st(0, 0, 0, 0, 1, 2),
          st(0, 0, 1, 0, 0, 0), st(0, 0, 0, 0, 1, 0)};
    foreach (s[i]) begin
      jmp = s[i].j; call = s[i].c; ret = s[i].r; tgt = s[i].t;
      sb.push_back('{s[i].v, s[i].pc});
      @(posedge clk); #1;
      e = sb.pop_front();
      runs++;
      if (instr_vld !== e.v || instr !== (e.v ? 12'(e.pc + 1) : 12'd0) ||
          (e.v && instr_pc !== e.pc)) begin
        fails++;
        $display("FAIL ovf[%0d]: vld=%b pc=%0d instr=%0d, want vld=%b pc=%0d",
                 i, instr_vld, instr_pc, instr, e.v, e.pc);
      end
      if (i == 5) begin
        runs++;
        if (err_ovf !== 1'b1 || err_unf !== 1'b0) begin
          fails++;
          $display("FAIL ovf_flag: ovf=%b unf=%b, want 1 0", err_ovf, err_unf);
        end
      end
    end
    runs++;
    if (err_ovf !== 1'b1 || err_unf !== 1'b1) begin
      fails++;
      $display("FAIL unf_flag: ovf=%b unf=%b, want 1 1", err_ovf, err_unf);
    end
  endtask

  task automatic test_back_to_back();
    st_t  s [10];
    exp_t e;
    s = '{st(0, 1, 1, 2, 0, 0), st(0, 0, 0, 0, 1, 2),
          st(1, 1, 0, 4, 0, 0), st(0, 0, 0, 0, 1, 4),
          st(0, 0, 1, 0, 0, 0), st(0, 0, 0, 0, 1, 1),
          st(1, 0, 0, 4, 0, 0), st(1, 0, 0, 0, 1, 4),
          st(0, 0, 0, 0, 1, 5), st(0, 0, 0, 0, 1, 0)};
    foreach (s[i]) begin
      jmp = s[i].j; call = s[i].c; ret = s[i].r; tgt = s[i].t;
      sb.push_back('{s[i].v, s[i].pc});
      @(posedge clk); #1;
      e = sb.pop_front();
      runs++;
      if (instr_vld !== e.v || instr !== (e.v ? 12'(e.pc + 1) : 12'd0) ||
          (e.v && instr_pc !== e.pc)) begin
        fails++;
        $display("FAIL b2b[%0d]: vld=%b pc=%0d instr=%0d, want vld=%b pc=%0d",
                 i, instr_vld, instr_pc, instr, e.v, e.pc);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    repeat (2) begin
      @(posedge clk); #1;
    end
    runs++;
    if (instr_vld !== 1'b1 || instr_pc !== 3'd2) begin
      fails++;
      $display("FAIL stall_pre: vld=%b pc=%0d, want 1 2", instr_vld, instr_pc);
    end
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1; jmp = (k == 1); tgt = 3'd5;
      #1;
      runs++;
      if (mem_addr !== 3'd2) begin
        fails++;
        $display("FAIL stall_addr[%0d]: addr=%0d, want 2", k, mem_addr);
      end
      sb.push_back('{1'b1, 3'd2});
      @(posedge clk); #1;
      e = sb.pop_front();
      runs++;
      if (instr_vld !== e.v || instr_pc !== e.pc || instr !== 12'(e.pc + 1)) begin
        fails++;
        $display("FAIL stall[%0d]: vld=%b pc=%0d instr=%0d, want vld=%b pc=%0d",
                 k, instr_vld, instr_pc, instr, e.v, e.pc);
      end
    end
    stall = 1'b0; jmp = 1'b0;
    for (int k = 3; k <= 4; k++) begin
      sb.push_back('{1'b1, 3'(k)});
      @(posedge clk); #1;
      e = sb.pop_front();
      runs++;
      if (instr_vld !== e.v || instr_pc !== e.pc || instr !== 12'(e.pc + 1)) begin
        fails++;
        $display("FAIL unstall[%0d]: vld=%b pc=%0d instr=%0d, want vld=%b pc=%0d",
                 k, instr_vld, instr_pc, instr, e.v, e.pc);
      end
    end
  endtask

  task automatic test_reset_mid();
    st_t  s [5];
    exp_t e;
    call = 1'b1; tgt = 3'd5;
    @(posedge clk); #1;
    call = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    runs++;
    if (instr_vld !== 1'b0 || mem_addr !== 3'd0 ||
        err_ovf !== 1'b0 || err_unf !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: vld=%b addr=%0d ovf=%b unf=%b, want 0 0 0 0",
               instr_vld, mem_addr, err_ovf, err_unf);
    end
    rst = 1'b1;
    s = '{st(0, 0, 0, 0, 1, 0), st(0, 0, 0, 0, 1, 1), st(0, 0, 0, 0, 1, 2),
          st(0, 0, 1, 0, 0, 0), st(0, 0, 0, 0, 1, 0)};
    foreach (s[i]) begin
      jmp = s[i].j; call = s[i].c; ret = s[i].r; tgt = s[i].t;
      sb.push_back('{s[i].v, s[i].pc});
      @(posedge clk); #1;
      e = sb.pop_front();
      runs++;
      if (instr_vld !== e.v || instr !== (e.v ? 12'(e.pc + 1) : 12'd0) ||
          (e.v && instr_pc !== e.pc)) begin
        fails++;
        $display("FAIL restart[%0d]: vld=%b pc=%0d instr=%0d, want vld=%b pc=%0d",
                 i, instr_vld, instr_pc, instr, e.v, e.pc);
      end
    end
    runs++;
    if (err_unf !== 1'b1 || err_ovf !== 1'b0) begin
      fails++;
      $display("FAIL sp_cleared: ovf=%b unf=%b, want 0 1", err_ovf, err_unf);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_call_ret();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule
